// File: rtl/p_unit_if.sv
// Bus bundle for one weight-stationary FP32 processing element.
// The driver of a/b/c/switch (neighbour or bench) takes the master view;
// the PE itself takes the slave view.
interface p_unit_if;
    logic [31:0] a;       // activation from the left neighbour
    logic [31:0] b;       // weight from the upper neighbour
    logic [31:0] c;       // partial sum in
    logic        switch;  // 1 = load W from b on this edge
    logic [31:0] ans;     // partial sum out
    logic [31:0] prop;    // b forwarded downward
    logic [31:0] a_prop;  // a forwarded rightward

    modport master (output a, b, c, switch, input ans, prop, a_prop);
    modport slave  (input a, b, c, switch, output ans, prop, a_prop);
endinterface

// File: rtl/p_unit.sv
// Weight-stationary FP32 processing element: ans = c + a*W every cycle.
// Both the multiply and the add round to nearest-even; subnormals are flushed,
// and special values are resolved to a canonical quiet NaN or a signed Inf.
module p_unit (
    input  logic        clk,
    input  logic        rst_n,
    p_unit_if.slave     bus
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // FP32 multiply with a single round-to-nearest-even step.
    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic               sr, x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
        logic [47:0]        m;
        logic [23:0]        sig;
        logic               g, s;
        logic [24:0]        rnd;
        logic [22:0]        frac;
        logic signed [9:0]  e;
        logic [31:0]        r;
        sr     = x[31] ^ y[31];
        x_zero = (x[30:23] == 8'h00);
        y_zero = (y[30:23] == 8'h00);
        x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
        y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'h0);
        x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
        y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'h0);
        m = {24'h0, 1'b1, x[22:0]} * {24'h0, 1'b1, y[22:0]};
        e = $signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]}) - 10'sd127;
        // Product of two [1,2) significands lies in [1,4): at most one normalising shift.
        if (m[47]) begin
            sig = m[47:24];
            g   = m[23];
            s   = |m[22:0];
            e   = e + 10'sd1;
        end else begin
            sig = m[46:23];
            g   = m[22];
            s   = |m[21:0];
        end
        rnd  = {1'b0, sig} + {24'h0, g & (s | sig[0])};
        frac = rnd[24] ? rnd[23:1] : rnd[22:0];
        if (rnd[24]) e = e + 10'sd1;
        if (x_nan || y_nan || (x_zero && y_inf) || (x_inf && y_zero)) r = QNAN;
        else if (x_inf || y_inf)       r = {sr, 8'hFF, 23'h0};
        else if (x_zero || y_zero)     r = {sr, 31'h0};
        else if (e >= 10'sd255)        r = {sr, 8'hFF, 23'h0};
        else if (e <= 10'sd0)          r = 32'h0;
        else                           r = {sr, e[7:0], frac};
        return r;
    endfunction

    // FP32 add with guard/round/sticky alignment and round-to-nearest-even.
    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic               x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
        logic               sb, ss;
        logic [7:0]         eb, es, d;
        logic [22:0]        fb, fs;
        logic [26:0]        mb, ms_full, ms, diff, n;
        logic [27:0]        sum;
        logic               st, zero_res;
        logic [4:0]         lz;
        logic [24:0]        rnd;
        logic [22:0]        frac;
        logic signed [9:0]  e;
        logic [31:0]        r;
        x_zero = (x[30:23] == 8'h00);
        y_zero = (y[30:23] == 8'h00);
        x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
        y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'h0);
        x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
        y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'h0);
        // Order operands by magnitude so the aligned difference is never negative.
        if (x[30:0] < y[30:0]) begin
            sb = y[31]; eb = y[30:23]; fb = y[22:0];
            ss = x[31]; es = x[30:23]; fs = x[22:0];
        end else begin
            sb = x[31]; eb = x[30:23]; fb = x[22:0];
            ss = y[31]; es = y[30:23]; fs = y[22:0];
        end
        mb      = {1'b1, fb, 3'b000};
        ms_full = {1'b1, fs, 3'b000};
        d       = eb - es;
        if (d >= 8'd27) begin
            ms = 27'h0;
            st = 1'b1;
        end else begin
            ms = ms_full >> d;
            st = |(ms_full & ((27'd1 << d) - 27'd1));
        end
        ms[0]    = ms[0] | st;
        e        = $signed({2'b00, eb});
        zero_res = 1'b0;
        lz       = 5'd0;
        sum      = 28'h0;
        diff     = 27'h0;
        if (sb == ss) begin
            sum = {1'b0, mb} + {1'b0, ms};
            if (sum[27]) begin
                n = {sum[27:2], sum[1] | sum[0]};
                e = e + 10'sd1;
            end else begin
                n = sum[26:0];
            end
        end else begin
            diff = mb - ms;
            zero_res = (diff == 27'h0);
            // Highest set bit wins because the scan runs upward.
            for (int i = 0; i < 27; i++) begin
                if (diff[i]) lz = 5'(26 - i);
            end
            n = diff << lz;
            e = e - $signed({5'b00000, lz});
        end
        rnd  = {1'b0, n[26:3]} + {24'h0, n[2] & (n[1] | n[0] | n[3])};
        frac = rnd[24] ? rnd[23:1] : rnd[22:0];
        if (rnd[24]) e = e + 10'sd1;
        if (x_nan || y_nan || (x_inf && y_inf && (x[31] != y[31]))) r = QNAN;
        else if (x_inf)              r = {x[31], 8'hFF, 23'h0};
        else if (y_inf)              r = {y[31], 8'hFF, 23'h0};
        else if (x_zero && y_zero)   r = {x[31] & y[31], 31'h0};
        else if (x_zero)             r = y;
        else if (y_zero)             r = x;
        else if (zero_res)           r = 32'h0;
        else if (e >= 10'sd255)      r = {sb, 8'hFF, 23'h0};
        else if (e <= 10'sd0)        r = 32'h0;
        else                         r = {sb, e[7:0], frac};
        return r;
    endfunction

    logic [31:0] w_q, w_d;
    logic [31:0] ans_q, ans_d;
    logic [31:0] prop_q, prop_d;
    logic [31:0] a_prop_q, a_prop_d;
    logic [31:0] prod;

    // The product always uses the weight held before this edge.
    assign prod = fp_mul(bus.a, w_q);

    // Next-state: MAC result, forwarded operands and optional weight reload.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        w_d      = w_q;
        if (bus.switch) w_d = bus.b;
        ans_d    = fp_add(bus.c, prod);
        prop_d   = bus.b;
        a_prop_d = bus.a;
    end

    // State registers, cleared to +0.0 by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q      <= 32'h0;
            ans_q    <= 32'h0;
            prop_q   <= 32'h0;
            a_prop_q <= 32'h0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, which is what keeps W_old in the product.
            w_q      <= w_d;
            ans_q    <= ans_d;
            prop_q   <= prop_d;
            a_prop_q <= a_prop_d;
        end
    end

    assign bus.ans    = ans_q;
    assign bus.prop   = prop_q;
    assign bus.a_prop = a_prop_q;
endmodule

// File: tb/tb_p_unit.sv
// Directed bench for p_unit: reset, weight load, hold, rounding, specials,
// back-to-back reload and asynchronous reset mid-stream.
module tb_p_unit;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    p_unit_if bus();

    p_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic sw);
        bus.a      = a;
        bus.b      = b;
        bus.c      = c;
        bus.switch = sw;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            drive($urandom, $urandom, $urandom, 1'($urandom));
            tick();
            n_cmp++;
            if ({bus.ans, bus.prop, bus.a_prop} !== 96'h0) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: ans=%h prop=%h a_prop=%h expected all 0",
                         i, bus.ans, bus.prop, bus.a_prop);
            end
        end
        rst_n = 1'b1;
        // W is still 0 after reset: ans = 0*1 + 3 = 3.0; W loads 2.0.
        drive(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b1);
        tick();
        n_cmp++;
        if (bus.ans !== 32'h4040_0000) begin
            n_err++;
            $display("FAIL reset_first_ans: got %h expected %h", bus.ans, 32'h4040_0000);
        end
        n_cmp++;
        if (bus.prop !== 32'h4000_0000) begin
            n_err++;
            $display("FAIL reset_first_prop: got %h expected %h", bus.prop, 32'h4000_0000);
        end
        n_cmp++;
        if (bus.a_prop !== 32'h3F80_0000) begin
            n_err++;
            $display("FAIL reset_first_aprop: got %h expected %h", bus.a_prop, 32'h3F80_0000);
        end
        drive(32'h3F80_0000, 32'h0, 32'h0, 1'b0);
        tick();
        n_cmp++;
        if (bus.ans !== 32'h4000_0000) begin
            n_err++;
            $display("FAIL reset_w_loaded: got %h expected %h", bus.ans, 32'h4000_0000);
        end
    endtask

    task automatic test_load_mac();
        drive(32'h0, 32'h4120_0000, 32'h0, 1'b1);
        tick();
        drive(32'h4260_0000, 32'h0, 32'h4260_0000, 1'b1);
        tick();
        n_cmp++;
        if (bus.ans !== 32'h441A_0000) begin
            n_err++;
            $display("FAIL mac_ans: got %h expected %h", bus.ans, 32'h441A_0000);
        end
        n_cmp++;
        if (bus.prop !== 32'h0) begin
            n_err++;
            $display("FAIL mac_prop: got %h expected %h", bus.prop, 32'h0);
        end
        n_cmp++;
        if (bus.a_prop !== 32'h4260_0000) begin
            n_err++;
            $display("FAIL mac_aprop: got %h expected %h", bus.a_prop, 32'h4260_0000);
        end
        // W became 0 on the previous edge: 0*56 + 1 = 1.0.
        drive(32'h4260_0000, 32'h0, 32'h3F80_0000, 1'b0);
        tick();
        n_cmp++;
        if (bus.ans !== 32'h3F80_0000) begin
            n_err++;
            $display("FAIL mac_w_zero: got %h expected %h", bus.ans, 32'h3F80_0000);
        end
    endtask

    task automatic test_hold();
        drive(32'h0, 32'h4000_0000, 32'h0, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(32'h4040_0000, 32'h40A0_0000, 32'h3F80_0000, 1'b0);
            tick();
            n_cmp++;
            if (bus.ans !== 32'h40E0_0000) begin
                n_err++;
                $display("FAIL hold_ans[%0d]: got %h expected %h", i, bus.ans, 32'h40E0_0000);
            end
            n_cmp++;
            if (bus.prop !== 32'h40A0_0000) begin
                n_err++;
                $display("FAIL hold_prop[%0d]: got %h expected %h", i, bus.prop, 32'h40A0_0000);
            end
        end
    endtask

    task automatic test_rounding();
        drive(32'h0, 32'h3F80_0000, 32'h0, 1'b1);
        tick();
        // 1+2^-23 + 2^-24: tie with odd LSB rounds up.
        drive(32'h3F80_0001, 32'h0, 32'h3380_0000, 1'b0);
        tick();
        n_cmp++;
        if (bus.ans !== 32'h3F80_0002) begin
            n_err++;
            $display("FAIL round_tie_up: got %h expected %h", bus.ans, 32'h3F80_0002);
        end
        // 1 + 2^-24: tie with even LSB stays.
        drive(32'h3F80_0000, 32'h0, 32'h3380_0000, 1'b0);
        tick();
        n_cmp++;
        if (bus.ans !== 32'h3F80_0000) begin
            n_err++;
            $display("FAIL round_tie_even: got %h expected %h", bus.ans, 32'h3F80_0000);
        end
    endtask

    task automatic test_specials();
        // W = 0: Inf * 0 -> canonical NaN.
        drive(32'h0, 32'h0, 32'h0, 1'b1);
        tick();
        drive(32'h7F80_0000, 32'h0, 32'h0, 1'b0);
        tick();
        n_cmp++;
        if (bus.ans !== 32'h7FC0_0000) begin
            n_err++;
            $display("FAIL inf_times_zero: got %h expected %h", bus.ans, 32'h7FC0_0000);
        end
        // W = 2.0: max finite * 2 overflows to +Inf.
        drive(32'h0, 32'h4000_0000, 32'h0, 1'b1);
        tick();
        drive(32'h7F7F_FFFF, 32'h0, 32'h0, 1'b0);
        tick();
        n_cmp++;
        if (bus.ans !== 32'h7F80_0000) begin
            n_err++;
            $display("FAIL overflow_inf: got %h expected %h", bus.ans, 32'h7F80_0000);
        end
        // W = 1.0: exact cancellation -> +0.
        drive(32'h0, 32'h3F80_0000, 32'h0, 1'b1);
        tick();
        drive(32'h3F80_0000, 32'h0, 32'hBF80_0000, 1'b0);
        tick();
        n_cmp++;
        if (bus.ans !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL cancel_zero: got %h expected %h", bus.ans, 32'h0);
        end
        // Inf + (-Inf) -> canonical NaN.
        drive(32'h7F80_0000, 32'h0, 32'hFF80_0000, 1'b0);
        tick();
        n_cmp++;
        if (bus.ans !== 32'h7FC0_0000) begin
            n_err++;
            $display("FAIL inf_minus_inf: got %h expected %h", bus.ans, 32'h7FC0_0000);
        end
        // NaN in c -> canonical NaN.
        drive(32'h3F80_0000, 32'h0, 32'h7F80_0001, 1'b0);
        tick();
        n_cmp++;
        if (bus.ans !== 32'h7FC0_0000) begin
            n_err++;
            $display("FAIL nan_in_c: got %h expected %h", bus.ans, 32'h7FC0_0000);
        end
        // -Inf * 1 + 1 -> -Inf.
        drive(32'hFF80_0000, 32'h0, 32'h3F80_0000, 1'b0);
        tick();
        n_cmp++;
        if (bus.ans !== 32'hFF80_0000) begin
            n_err++;
            $display("FAIL neg_inf_prop: got %h expected %h", bus.ans, 32'hFF80_0000);
        end
        // Subnormal a flushed to zero: 0*1 + 1 = 1.0.
        drive(32'h0000_0001, 32'h0, 32'h3F80_0000, 1'b0);
        tick();
        n_cmp++;
        if (bus.ans !== 32'h3F80_0000) begin
            n_err++;
            $display("FAIL subnormal_flush: got %h expected %h", bus.ans, 32'h3F80_0000);
        end
    endtask

    task automatic test_back_to_back();
        drive(32'h0, 32'h4000_0000, 32'h0, 1'b1);
        tick();
        // Reload with compute on the same edge: old W=2 gives 6, new W=4 gives 12.
        drive(32'h4040_0000, 32'h4080_0000, 32'h0, 1'b1);
        tick();
        n_cmp++;
        if (bus.ans !== 32'h40C0_0000) begin
            n_err++;
            $display("FAIL b2b_old_w: got %h expected %h", bus.ans, 32'h40C0_0000);
        end
        drive(32'h4040_0000, 32'h0, 32'h0, 1'b0);
        tick();
        n_cmp++;
        if (bus.ans !== 32'h4140_0000) begin
            n_err++;
            $display("FAIL b2b_new_w: got %h expected %h", bus.ans, 32'h4140_0000);
        end
    endtask

    task automatic test_async_reset();
        drive(32'h0, 32'h4000_0000, 32'h0, 1'b1);
        tick();
        drive(32'h4040_0000, 32'h4040_0000, 32'h3F80_0000, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.ans, bus.prop, bus.a_prop} !== 96'h0) begin
            n_err++;
            $display("FAIL async_clear: ans=%h prop=%h a_prop=%h expected all 0",
                     bus.ans, bus.prop, bus.a_prop);
        end
        rst_n = 1'b1;
        drive(32'h4040_0000, 32'h0, 32'h40A0_0000, 1'b0);
        tick();
        n_cmp++;
        if (bus.ans !== 32'h40A0_0000) begin
            n_err++;
            $display("FAIL async_w_cleared: got %h expected %h", bus.ans, 32'h40A0_0000);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 1'b0);
        test_reset();
        test_load_mac();
        test_hold();
        test_rounding();
        test_specials();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
